// File: rtl/c4_custom_writeback_if.sv
// Bundle/writeback signal group between C3, the writeback stage and the register files.
// master = C3-side producer and RF consumer; slave = the writeback stage itself.
interface c4_custom_writeback_if #(
  parameter int unsigned VLEN = 128
) ();
  logic            in_v;
  logic [4:0]      in_rd;
  logic [2:0]      in_vrd1;
  logic [2:0]      in_vrd2;
  logic [1:0]      in_vwe;
  logic [31:0]     in_data;
  logic [VLEN-1:0] in_vdata1;
  logic [VLEN-1:0] in_vdata2;
  logic            in_ready;
  logic            x_we;
  logic [4:0]      x_waddr;
  logic [31:0]     x_wdata;
  logic            v_we;
  logic [2:0]      v_waddr;
  logic [VLEN-1:0] v_wdata;
  logic            overflow;

  modport master (
    output in_v, in_rd, in_vrd1, in_vrd2, in_vwe, in_data, in_vdata1, in_vdata2,
    input  in_ready, x_we, x_waddr, x_wdata, v_we, v_waddr, v_wdata, overflow
  );

  modport slave (
    input  in_v, in_rd, in_vrd1, in_vrd2, in_vwe, in_data, in_vdata1, in_vdata2,
    output in_ready, x_we, x_waddr, x_wdata, v_we, v_waddr, v_wdata, overflow
  );
endinterface

// File: rtl/c4_custom_writeback.sv
// C4 writeback: queues C3 result bundles and drains them into the scalar and vector RF
// write ports, splitting dual-vector bundles into two beats.
module c4_custom_writeback #(
  parameter int unsigned VLEN  = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  c4_custom_writeback_if.slave wb
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [4:0]      rd;
    logic [2:0]      vrd1;
    logic [2:0]      vrd2;
    logic [1:0]      vwe;
    logic [31:0]     data;
    logic [VLEN-1:0] vdata1;
    logic [VLEN-1:0] vdata2;
  } entry_t;

  typedef enum logic [1:0] {StIdle, StWb1, StWb2} state_e;

  entry_t          r_mem [DEPTH];
  logic [PtrW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0] r_count;
  state_e          r_state;
  logic            r_overflow;

  logic            r_x_we, r_v_we;
  logic [4:0]      r_x_waddr;
  logic [31:0]     r_x_wdata;
  logic [2:0]      r_v_waddr;
  logic [VLEN-1:0] r_v_wdata;

  state_e          w_state_nxt;
  entry_t          w_in, w_head, w_next, w_sel;
  logic [PtrW-1:0] w_rd_ptr_inc;
  logic            w_ready, w_push, w_pop, w_head_dual;
  logic            w_load_b1, w_load_b2;
  logic            w_x_we_d, w_v_we_d;
  logic [4:0]      w_x_waddr_d;
  logic [31:0]     w_x_wdata_d;
  logic [2:0]      w_v_waddr_d;
  logic [VLEN-1:0] w_v_wdata_d;

  assign w_ready      = (r_count < CntW'(DEPTH));
  assign w_push       = wb.in_v && w_ready;
  assign w_rd_ptr_inc = r_rd_ptr + PtrW'(1);
  assign w_head       = r_mem[r_rd_ptr];
  assign w_next       = r_mem[w_rd_ptr_inc];
  assign w_head_dual  = (w_head.vwe == 2'b11) && (w_head.vrd1 != w_head.vrd2);
  // From IDLE the first beat comes from the head; otherwise the head is popping this edge.
  assign w_sel        = (r_state == StIdle) ? w_head : w_next;

  always_comb begin
    w_in        = '0;
    w_in.rd     = wb.in_rd;
    w_in.vrd1   = wb.in_vrd1;
    w_in.vrd2   = wb.in_vrd2;
    w_in.vwe    = wb.in_vwe;
    w_in.data   = wb.in_data;
    w_in.vdata1 = wb.in_vdata1;
    w_in.vdata2 = wb.in_vdata2;
  end

  always_comb begin
    w_state_nxt = StIdle;
    w_pop       = 1'b0;
    w_load_b1   = 1'b0;
    w_load_b2   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_count != '0) begin
          w_state_nxt = StWb1;
          w_load_b1   = 1'b1;
        end
      end
      StWb1: begin
        if (w_head_dual) begin
          w_state_nxt = StWb2;
          w_load_b2   = 1'b1;
        end else begin
          w_pop = 1'b1;
          if (r_count > CntW'(1)) begin
            w_state_nxt = StWb1;
            w_load_b1   = 1'b1;
          end
        end
      end
      StWb2: begin
        w_pop = 1'b1;
        if (r_count > CntW'(1)) begin
          w_state_nxt = StWb1;
          w_load_b1   = 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_x_we_d    = 1'b0;
    w_x_waddr_d = '0;
    w_x_wdata_d = '0;
    w_v_we_d    = 1'b0;
    w_v_waddr_d = '0;
    w_v_wdata_d = '0;
    if (w_load_b1) begin
      if (w_sel.rd != '0) begin
        w_x_we_d    = 1'b1;
        w_x_waddr_d = w_sel.rd;
        w_x_wdata_d = w_sel.data;
      end
      // Same-register dual write collapses to one beat; the second result wins.
      if ((w_sel.vwe == 2'b11) && (w_sel.vrd1 == w_sel.vrd2)) begin
        w_v_we_d    = 1'b1;
        w_v_waddr_d = w_sel.vrd2;
        w_v_wdata_d = w_sel.vdata2;
      end else if (w_sel.vwe[0]) begin
        w_v_we_d    = 1'b1;
        w_v_waddr_d = w_sel.vrd1;
        w_v_wdata_d = w_sel.vdata1;
      end else if (w_sel.vwe[1]) begin
        w_v_we_d    = 1'b1;
        w_v_waddr_d = w_sel.vrd2;
        w_v_wdata_d = w_sel.vdata2;
      end
    end else if (w_load_b2) begin
      w_v_we_d    = 1'b1;
      w_v_waddr_d = w_head.vrd2;
      w_v_wdata_d = w_head.vdata2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_state    <= StIdle;
      r_overflow <= 1'b0;
      r_x_we     <= 1'b0;
      r_x_waddr  <= '0;
      r_x_wdata  <= '0;
      r_v_we     <= 1'b0;
      r_v_waddr  <= '0;
      r_v_wdata  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_in;
        r_wr_ptr        <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) r_rd_ptr <= w_rd_ptr_inc;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
      if (wb.in_v && !w_ready) r_overflow <= 1'b1;
      r_state   <= w_state_nxt;
      r_x_we    <= w_x_we_d;
      r_x_waddr <= w_x_waddr_d;
      r_x_wdata <= w_x_wdata_d;
      r_v_we    <= w_v_we_d;
      r_v_waddr <= w_v_waddr_d;
      r_v_wdata <= w_v_wdata_d;
    end
  end

  assign wb.in_ready = w_ready;
  assign wb.x_we     = r_x_we;
  assign wb.x_waddr  = r_x_waddr;
  assign wb.x_wdata  = r_x_wdata;
  assign wb.v_we     = r_v_we;
  assign wb.v_waddr  = r_v_waddr;
  assign wb.v_wdata  = r_v_wdata;
  assign wb.overflow = r_overflow;
endmodule
